// File: rtl/glb_tile_pcfg_dma.sv
// rtl/glb_tile_pcfg_dma.sv - Bank-to-CGRA config-packet DMA; optional PCFG_DMA_PERF_CNT_EN adds pc_cycle_cnt
module glb_tile_pcfg_dma #(
    parameter int ADDR_WIDTH     = 22,
    parameter int NUM_CFG_WIDTH  = 20,
    parameter int RD_LATENCY     = 2,
    parameter int CFG_ADDR_WIDTH = 32,
    parameter int CFG_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     cfg_pc_start_addr,
    input  logic [NUM_CFG_WIDTH-1:0]  cfg_pc_num_cfg,
    input  logic                      pc_start_pulse,
    output logic                      pc_busy,
    output logic                      pc_done_pulse,
    output logic                      bank_rd_en,
    output logic [ADDR_WIDTH-1:0]     bank_rd_addr,
    input  logic [63:0]               bank_rd_data,
    input  logic                      bank_rd_data_valid,
    output logic                      cgra_cfg_c2sw_wr_en,
    output logic                      cgra_cfg_c2sw_rd_en,
    output logic [CFG_ADDR_WIDTH-1:0] cgra_cfg_c2sw_addr,
    output logic [CFG_DATA_WIDTH-1:0] cgra_cfg_c2sw_data
`ifdef PCFG_DMA_PERF_CNT_EN
    ,
    output logic [31:0]               pc_cycle_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // The bank read return is expected a fixed 1..4 cycles after the request.
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_rd_latency
        $error("glb_tile_pcfg_dma: RD_LATENCY must be in 1..4");
    end

    state_t                   state_q;
    state_t                   state_d;
    logic [NUM_CFG_WIDTH-1:0] num_q;
    logic [NUM_CFG_WIDTH-1:0] req_cnt_q;
    logic [NUM_CFG_WIDTH-1:0] rcv_cnt_q;
    logic [NUM_CFG_WIDTH-1:0] last_idx;
    logic [ADDR_WIDTH-1:0]    rd_addr_q;
    logic                     start_accept;
    logic                     rd_accept;

    assign last_idx     = num_q - NUM_CFG_WIDTH'(1);
    assign start_accept = (state_q == ST_IDLE) && pc_start_pulse && (cfg_pc_num_cfg != '0);
    // Returns are only meaningful while a transfer is live; stray data in IDLE/DONE is dropped.
    assign rd_accept    = bank_rd_data_valid && ((state_q == ST_REQ) || (state_q == ST_DRAIN));

    assign pc_busy             = (state_q != ST_IDLE);
    assign bank_rd_en          = (state_q == ST_REQ);
    assign bank_rd_addr        = bank_rd_en ? rd_addr_q : '0;
    assign cgra_cfg_c2sw_rd_en = 1'b0;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: issue all reads, wait for all returns, then one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pc_start_pulse) begin
                    state_d = (cfg_pc_num_cfg == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (req_cnt_q == last_idx) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bank_rd_data_valid && (rcv_cnt_q == last_idx)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch the job on an accepted start, then advance request address and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_q     <= '0;
            rd_addr_q <= '0;
            req_cnt_q <= '0;
            rcv_cnt_q <= '0;
        end else if (start_accept) begin
            num_q     <= cfg_pc_num_cfg;
            rd_addr_q <= cfg_pc_start_addr;
            req_cnt_q <= '0;
            rcv_cnt_q <= '0;
        end else begin
            if (state_q == ST_REQ) begin
                rd_addr_q <= rd_addr_q + ADDR_WIDTH'(8);
                req_cnt_q <= req_cnt_q + NUM_CFG_WIDTH'(1);
            end
            if (rd_accept) begin
                rcv_cnt_q <= rcv_cnt_q + NUM_CFG_WIDTH'(1);
            end
        end
    end

    // Register one config packet per accepted return word; bus is zero between packets.
    always_ff @(posedge clk) begin
        if (reset) begin
            cgra_cfg_c2sw_wr_en <= 1'b0;
            cgra_cfg_c2sw_addr  <= '0;
            cgra_cfg_c2sw_data  <= '0;
        end else begin
            cgra_cfg_c2sw_wr_en <= rd_accept;
            cgra_cfg_c2sw_addr  <= rd_accept ? CFG_ADDR_WIDTH'(bank_rd_data[63:32]) : '0;
            cgra_cfg_c2sw_data  <= rd_accept ? CFG_DATA_WIDTH'(bank_rd_data[31:0]) : '0;
        end
    end

    // Done pulse follows the single DONE cycle, so a zero-length job reports at start+2.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_done_pulse <= 1'b0;
        end else begin
            pc_done_pulse <= (state_q == ST_DONE);
        end
    end

`ifdef PCFG_DMA_PERF_CNT_EN
    // Job duration: clears on start, counts busy cycles plus the done-pulse cycle, saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_cycle_cnt <= '0;
        end else if ((state_q == ST_IDLE) && pc_start_pulse) begin
            pc_cycle_cnt <= '0;
        end else if ((pc_busy || pc_done_pulse) && (pc_cycle_cnt != '1)) begin
            pc_cycle_cnt <= pc_cycle_cnt + 32'd1;
        end
    end
`endif

endmodule
